// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder.
// Optional feature macro: DMEM_MISALIGN_CHECK_EN (be_legal is only used when it is defined).
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_t;

    localparam int WORD_W = 32;
    localparam int BE_W   = 4;

    // Legal store byte-enable patterns for a given byte offset within the word:
    // full word at 0, halfword at 0 or 2, or a single byte matching the offset.
    function automatic logic be_legal(input logic [1:0] offset, input logic [BE_W-1:0] be);
        logic ok;
        case (offset)
            2'd0:    ok = (be == 4'b1111) || (be == 4'b0011) || (be == 4'b0001);
            2'd1:    ok = (be == 4'b0010);
            2'd2:    ok = (be == 4'b1100) || (be == 4'b0100);
            default: ok = (be == 4'b1000);
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-organised data storage: synchronous byte-enabled write, combinational read
// from the same word address.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024
) (
    input  logic                           clk,
    input  logic                           wr_en_i,
    input  logic [$clog2(DEPTH_WORDS)-1:0] addr_i,
    input  logic [BE_W-1:0]                wr_be_i,
    input  logic [WORD_W-1:0]              wr_data_i,
    output logic [WORD_W-1:0]              rd_data_o
);

    logic [WORD_W-1:0] mem_q [DEPTH_WORDS];

    // Byte-lane write of the enabled lanes.
    // NOTE: the storage is deliberately left out of reset; contents survive rst and
    // the array stays mappable onto a plain RAM macro.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            for (int b = 0; b < BE_W; b++) begin
                if (wr_be_i[b]) begin
                    mem_q[addr_i][8*b +: 8] <= wr_data_i[8*b +: 8];
                end
            end
        end
    end

    assign rd_data_o = mem_q[addr_i];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one load/store in flight, fixed LATENCY wait states between
// request accept and response valid, response held until the core takes it.
// Optional feature macro: DMEM_MISALIGN_CHECK_EN (flags misaligned accesses via rsp_err).
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy
);

    localparam int         AW  = $clog2(DEPTH_WORDS);
    localparam logic [3:0] LAT = 4'(LATENCY);

    dmem_state_t       state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              accept;

    // Latched request
    logic              we_q;
    logic [AW-1:0]     idx_q;
    logic [1:0]        off_q;
    logic [WORD_W-1:0] wdata_q;
    logic [BE_W-1:0]   be_q;

    // Response registers
    logic [WORD_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;

    // Transaction currently being served; with LATENCY = 0 the response is built on
    // the accept edge, before the latched copy exists, so the live inputs are used.
    logic              cur_we;
    logic [AW-1:0]     cur_idx;
    logic [1:0]        cur_off;
    logic [WORD_W-1:0] cur_wdata;
    logic [BE_W-1:0]   cur_be;
    logic              enter_resp;
    logic              txn_err;
    logic              mem_wr_en;
    logic [WORD_W-1:0] mem_rd;
    logic [WORD_W-1:0] merged;

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign busy      = (state_q != IDLE);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

    // Next-state and wait-counter logic.
    // NOTE: every variable gets a default before the case so no latch is inferred.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    accept  = 1'b1;
                    cnt_d   = LAT;
                    state_d = (LAT != 4'd0) ? WAIT : RESP;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Select the live request in IDLE, the latched one otherwise.
    always_comb begin
        if (state_q == IDLE) begin
            cur_we    = req_we;
            cur_idx   = req_addr[AW+1:2];
            cur_off   = req_addr[1:0];
            cur_wdata = req_wdata;
            cur_be    = req_be;
        end else begin
            cur_we    = we_q;
            cur_idx   = idx_q;
            cur_off   = off_q;
            cur_wdata = wdata_q;
            cur_be    = be_q;
        end
    end

    assign enter_resp = (state_d == RESP) && (state_q != RESP);

`ifdef DMEM_MISALIGN_CHECK_EN
    assign txn_err = cur_we ? !be_legal(cur_off, cur_be) : (cur_off != 2'd0);
    logic unused_addr_bits;
    assign unused_addr_bits = ^req_addr[31:AW+2];
`else
    assign txn_err = 1'b0;
    logic unused_addr_bits;
    assign unused_addr_bits = ^{req_addr[31:AW+2], cur_off};
`endif

    // Post-write word: enabled lanes from the store data, the rest from memory.
    always_comb begin
        merged = mem_rd;
        for (int b = 0; b < BE_W; b++) begin
            if (cur_be[b]) begin
                merged[8*b +: 8] = cur_wdata[8*b +: 8];
            end
        end
    end

    // Reset blocks the write so a store dropped by rst never reaches memory.
    assign mem_wr_en = enter_resp && cur_we && !txn_err && !rst;

    // Response data is captured on the edge that enters RESP and then held.
    always_comb begin
        rdata_d = rdata_q;
        err_d   = err_q;
        if (enter_resp) begin
            err_d   = txn_err;
            rdata_d = txn_err ? '0 : (cur_we ? merged : mem_rd);
        end
    end

    // State, counter, request latch and response registers.
    // NOTE: sequential state uses non-blocking assignments so all registers update
    // together on the edge regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
            idx_q   <= '0;
            off_q   <= '0;
            wdata_q <= '0;
            be_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            if (accept) begin
                we_q    <= req_we;
                idx_q   <= req_addr[AW+1:2];
                off_q   <= req_addr[1:0];
                wdata_q <= req_wdata;
                be_q    <= req_be;
            end
        end
    end

    dmem_array #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_array (
        .clk       (clk),
        .wr_en_i   (mem_wr_en),
        .addr_i    (cur_idx),
        .wr_be_i   (cur_be),
        .wr_data_i (cur_wdata),
        .rd_data_o (mem_rd)
    );

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: a LATENCY=2 instance exercised with
// directed and random traffic, and a LATENCY=0 instance for back-to-back spacing.
// Honours DMEM_MISALIGN_CHECK_EN in its reference model.
module tb_dmem_responder;

    localparam int DEPTH = 1024;

    logic        clk = 1'b0;
    logic        rst;

    logic        req_valid, req_ready, req_we;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_be;
    logic        rsp_valid, rsp_ready, rsp_err, busy;
    logic [31:0] rsp_rdata;

    logic        req_valid_z, req_ready_z, req_we_z;
    logic [31:0] req_addr_z, req_wdata_z;
    logic [3:0]  req_be_z;
    logic        rsp_valid_z, rsp_ready_z, rsp_err_z, busy_z;
    logic [31:0] rsp_rdata_z;

    int checks   = 0;
    int failures = 0;

    logic [31:0] mdl  [DEPTH];
    logic [31:0] mdl0 [DEPTH];

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(2)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .busy(busy)
    );

    dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(0)) dut0 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid_z), .req_ready(req_ready_z), .req_we(req_we_z),
        .req_addr(req_addr_z), .req_wdata(req_wdata_z), .req_be(req_be_z),
        .rsp_valid(rsp_valid_z), .rsp_ready(rsp_ready_z), .rsp_rdata(rsp_rdata_z),
        .rsp_err(rsp_err_z), .busy(busy_z)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_b(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Byte-lane merge of new data over an old word.
    function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old_w;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
        end
        return r;
    endfunction

    // Expected error flag from the access rules.
    function automatic logic model_err(input logic we, input logic [1:0] off, input logic [3:0] be);
`ifdef DMEM_MISALIGN_CHECK_EN
        if (!we) return off != 2'd0;
        case (off)
            2'd0:    return !(be inside {4'b1111, 4'b0011, 4'b0001});
            2'd1:    return be != 4'b0010;
            2'd2:    return !(be inside {4'b1100, 4'b0100});
            default: return be != 4'b1000;
        endcase
`else
        return 1'b0;
`endif
    endfunction

    // One transaction on the LATENCY=2 instance, with 'hold' cycles of response backpressure.
    task automatic run_op(input string tag, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] be, input int hold);
        int          idx;
        int          w;
        int          lat;
        logic [31:0] exp_rd;
        logic        exp_err;
        logic [1:0]  off;
        idx     = int'((addr >> 2) % DEPTH);
        off     = addr[1:0];
        exp_err = model_err(we, off, be);
        if (exp_err) begin
            exp_rd = '0;
        end else if (we) begin
            mdl[idx] = merge(mdl[idx], wdata, be);
            exp_rd   = mdl[idx];
        end else begin
            exp_rd = mdl[idx];
        end

        w = 0;
        while (!req_ready && w < 20) begin
            tick();
            w++;
        end
        check_b({tag, " req_ready"}, req_ready, 1'b1);

        rsp_ready = (hold == 0);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_be    = be;
        tick();
        req_valid = 1'b0;
        req_we    = $urandom_range(0, 1);
        req_addr  = $urandom;
        req_wdata = $urandom;
        req_be    = 4'($urandom);
        check_b({tag, " busy"}, busy, 1'b1);

        lat = 1;
        while (!rsp_valid && lat < 40) begin
            tick();
            lat++;
        end
        check({tag, " latency"}, lat, 32'd3);
        check({tag, " rdata"}, rsp_rdata, exp_rd);
        check_b({tag, " err"}, rsp_err, exp_err);

        for (int h = 0; h < hold; h++) begin
            check_b({tag, " hold valid"}, rsp_valid, 1'b1);
            check({tag, " hold rdata"}, rsp_rdata, exp_rd);
            check_b({tag, " hold req_ready"}, req_ready, 1'b0);
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        check_b({tag, " done valid"}, rsp_valid, 1'b0);
        check_b({tag, " done req_ready"}, req_ready, 1'b1);
        check_b({tag, " done busy"}, busy, 1'b0);
    endtask

    // One transaction on the LATENCY=0 instance; a new one may start two cycles later.
    task automatic run0(input string tag, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be);
        int          idx;
        logic [31:0] exp_rd;
        idx = int'((addr >> 2) % DEPTH);
        if (we) begin
            mdl0[idx] = merge(mdl0[idx], wdata, be);
        end
        exp_rd = mdl0[idx];
        check_b({tag, " req_ready"}, req_ready_z, 1'b1);
        req_valid_z = 1'b1;
        req_we_z    = we;
        req_addr_z  = addr;
        req_wdata_z = wdata;
        req_be_z    = be;
        tick();
        req_valid_z = 1'b0;
        check_b({tag, " valid"}, rsp_valid_z, 1'b1);
        check({tag, " rdata"}, rsp_rdata_z, exp_rd);
        check_b({tag, " req_ready low"}, req_ready_z, 1'b0);
        tick();
        check_b({tag, " valid drop"}, rsp_valid_z, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        logic [31:0] upper;

        rst         = 1'b1;
        req_valid   = 1'b0; req_we   = 1'b0; req_addr   = '0; req_wdata   = '0; req_be   = '0;
        rsp_ready   = 1'b1;
        req_valid_z = 1'b0; req_we_z = 1'b0; req_addr_z = '0; req_wdata_z = '0; req_be_z = '0;
        rsp_ready_z = 1'b1;
        repeat (3) tick();
        rst = 1'b0;

        // Reset state
        check_b("rst req_ready", req_ready, 1'b1);
        check_b("rst rsp_valid", rsp_valid, 1'b0);
        check("rst rsp_rdata", rsp_rdata, 32'h0);
        check_b("rst rsp_err", rsp_err, 1'b0);
        check_b("rst busy", busy, 1'b0);
        check_b("rst0 req_ready", req_ready_z, 1'b1);

        // Give the first 16 words known contents
        for (int i = 0; i < 16; i++) begin
            a = 32'(i * 4);
            run_op("init", 1'b1, a, $urandom, 4'hF, 0);
        end

        // Directed cases
        run_op("st full",   1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0);
        run_op("ld full",   1'b0, 32'h10, 32'h0, 4'h0, 0);
        run_op("st byte",   1'b1, 32'h10, 32'h000000AA, 4'b0001, 0);
        run_op("ld byte",   1'b0, 32'h10, 32'h0, 4'hF, 0);
        run_op("st be0",    1'b1, 32'h10, 32'h11223344, 4'b0000, 0);
        run_op("ld be0",    1'b0, 32'h10, 32'h0, 4'h0, 0);
        run_op("ld bp",     1'b0, 32'h10, 32'h0, 4'h0, 5);
        run_op("st wrap",   1'b1, 32'h1000, 32'hCAFEF00D, 4'hF, 0);
        run_op("ld wrap",   1'b0, 32'h0, 32'h0, 4'h0, 0);
        run_op("st mis F",  1'b1, 32'h13, 32'h55667788, 4'hF, 0);
        run_op("ld mis",    1'b0, 32'h10, 32'h0, 4'h0, 0);
        run_op("st mis b3", 1'b1, 32'h13, 32'h77000000, 4'b1000, 0);
        run_op("ld mis b3", 1'b0, 32'h10, 32'h0, 4'h0, 0);

        // Reset during WAIT of a store: the store must be dropped
        check_b("rstw req_ready", req_ready, 1'b1);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'h12345678; req_be = 4'hF;
        tick();
        req_valid = 1'b0;
        check_b("rstw busy", busy, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_b("rstw valid", rsp_valid, 1'b0);
        check_b("rstw busy idle", busy, 1'b0);
        check_b("rstw req_ready idle", req_ready, 1'b1);
        for (int i = 0; i < 4; i++) begin
            tick();
            check_b("rstw quiet", rsp_valid, 1'b0);
        end
        run_op("rstw ld", 1'b0, 32'h20, 32'h0, 4'h0, 0);

        // Random traffic over the initialised words, with aliasing upper bits
        for (int n = 0; n < 40; n++) begin
            upper = $urandom;
            a = (upper & ~32'h0000_0FFF) | 32'($urandom_range(0, 15) * 4) | 32'($urandom_range(0, 3));
            run_op("rand", 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom), $urandom_range(0, 2));
        end

        // LATENCY=0 instance: back-to-back traffic, one accept every two cycles
        run0("z st3", 1'b1, 32'h0C, 32'hA5A5_0001, 4'hF);
        run0("z st5", 1'b1, 32'h14, 32'h5A5A_0002, 4'hF);
        run0("z ld3", 1'b0, 32'h0C, 32'h0, 4'h0);
        run0("z ld5", 1'b0, 32'h14, 32'h0, 4'h0);
        run0("z stb", 1'b1, 32'h14, 32'h0000_EE00, 4'b0010);
        run0("z ldb", 1'b0, 32'h14, 32'h0, 4'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
